// File: rtl/qcw_pkg.sv
// Shared constants and config helpers for the QCW oscillator and qcw_driver.
// Holds the counter width, default deadtime, minimum-period clamp and the config derivation.
package qcw_pkg;

  localparam int CNT_W            = 16;
  localparam int PHASE_W          = 8;
  localparam int DEADTIME_DEFAULT = 12;
  localparam int MIN_PERIOD       = 2 * DEADTIME_DEFAULT + 4;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } osc_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shift;
  } osc_cfg_t;

  function automatic logic [CNT_W-1:0] min_period(input int deadtime);
    return CNT_W'(2 * deadtime + 4);
  endfunction

  // Period is forced even and clamped so both half periods can hold their deadtime plus a pulse.
  function automatic osc_cfg_t make_cfg(input logic [CNT_W-1:0]   period_in,
                                        input logic [PHASE_W-1:0] phase,
                                        input logic [CNT_W-1:0]   min_p);
    osc_cfg_t                 cfg;
    logic [CNT_W-1:0]         p;
    logic [CNT_W+PHASE_W-1:0] prod;
    p = {period_in[CNT_W-1:1], 1'b0};
    if (p < min_p) p = min_p;
    cfg.period = p;
    cfg.half   = {1'b0, p[CNT_W-1:1]};
    prod       = (CNT_W+PHASE_W)'(cfg.half) * (CNT_W+PHASE_W)'(phase);
    cfg.shift  = prod[CNT_W+PHASE_W-1:PHASE_W];
    return cfg;
  endfunction

endpackage

// File: rtl/qcw_leg_decode.sv
// Half-bridge leg gate decode: maps a position within the period to high/low-side gates
// with deadtime after each half-period boundary.
module qcw_leg_decode
  import qcw_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEFAULT
) (
  input  logic [CNT_W-1:0] pos,
  input  logic [CNT_W-1:0] half,
  input  logic [CNT_W-1:0] period,
  output logic             hi,
  output logic             lo
);

  localparam logic [CNT_W:0] DT = (CNT_W+1)'(DEADTIME);

  assign hi = ({1'b0, pos} >= DT) && (pos < half);
  assign lo = ({1'b0, pos} >= ({1'b0, half} + DT)) && (pos < period);

endmodule

// File: rtl/qcw_oscillator.sv
// Phase-shifted full-bridge gate generator with shadowed period/phase reload each period.
// Optional macro OSC_GATE_INTERLOCK_EN adds a sticky shoot-through interlock on the gates.
module qcw_oscillator
  import qcw_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               load,
  input  logic [CNT_W-1:0]   period_value,
  input  logic [PHASE_W-1:0] phase_shift,
  output logic               period_done,
  output logic               signal_ref,
  output logic               sw1,
  output logic               sw2,
  output logic               sw3,
  output logic               sw4
);

  localparam logic [CNT_W-1:0] MIN_P = min_period(DEADTIME);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  osc_state_t         state, state_next;
  osc_cfg_t           cfg, new_cfg;
  logic [CNT_W-1:0]   cnt, cb;
  logic [CNT_W-1:0]   sh_period;
  logic [PHASE_W-1:0] sh_phase;
  logic               first_period;
  logic               running, starting, wrapping;
  logic               a_hi, a_lo, b_hi, b_lo, leg_b_hold;
  logic               g1_next, g2_next, g3_next, g4_next;

  assign running  = (state == ST_RUN) && enable;
  assign starting = (state == ST_IDLE) && enable;
  assign wrapping = (cnt == cfg.period - ONE);

  // A load on the transfer edge itself takes effect immediately rather than a period later.
  assign new_cfg = make_cfg(load ? period_value : sh_period,
                            load ? phase_shift  : sh_phase, MIN_P);

  assign cb = (cnt >= cfg.shift) ? (cnt - cfg.shift) : (cnt + (cfg.period - cfg.shift));
  assign leg_b_hold = first_period && (cnt < cfg.shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable)  state_next = ST_RUN;
      ST_RUN:  if (!enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      cfg          <= '0;
      sh_period    <= '0;
      sh_phase     <= '0;
      first_period <= 1'b1;
    end else begin
      if (load) begin
        sh_period <= {period_value[CNT_W-1:1], 1'b0};
        sh_phase  <= phase_shift;
      end
      cnt <= (running && !wrapping) ? cnt + ONE : '0;
      if (starting || (running && wrapping)) cfg <= new_cfg;
      if (starting)                   first_period <= 1'b1;
      else if (running && wrapping)   first_period <= 1'b0;
    end
  end

  qcw_leg_decode #(.DEADTIME(DEADTIME)) u_leg_a (
    .pos    (cnt),
    .half   (cfg.half),
    .period (cfg.period),
    .hi     (a_hi),
    .lo     (a_lo)
  );

  qcw_leg_decode #(.DEADTIME(DEADTIME)) u_leg_b (
    .pos    (cb),
    .half   (cfg.half),
    .period (cfg.period),
    .hi     (b_hi),
    .lo     (b_lo)
  );

`ifdef OSC_GATE_INTERLOCK_EN
  logic fault, a_clash, b_clash;

  assign a_clash = a_hi & a_lo;
  assign b_clash = b_hi & b_lo & ~leg_b_hold;

  // Once a clash is seen the bridge stays dark until the controller drops enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           fault <= 1'b0;
    else if (!enable)                  fault <= 1'b0;
    else if (running && (a_clash || b_clash)) fault <= 1'b1;
  end

  assign g1_next = a_hi & ~a_clash & ~fault;
  assign g2_next = a_lo & ~a_clash & ~fault;
  assign g3_next = b_hi & ~leg_b_hold & ~b_clash & ~fault;
  assign g4_next = b_lo & ~leg_b_hold & ~b_clash & ~fault;
`else
  assign g1_next = a_hi;
  assign g2_next = a_lo;
  assign g3_next = b_hi & ~leg_b_hold;
  assign g4_next = b_lo & ~leg_b_hold;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_done <= 1'b0;
      signal_ref  <= 1'b0;
      sw1         <= 1'b0;
      sw2         <= 1'b0;
      sw3         <= 1'b0;
      sw4         <= 1'b0;
    end else if (running) begin
      period_done <= wrapping;
      signal_ref  <= (cnt < cfg.half);
      sw1         <= g1_next;
      sw2         <= g2_next;
      sw3         <= g3_next;
      sw4         <= g4_next;
    end else begin
      period_done <= 1'b0;
      signal_ref  <= 1'b0;
      sw1         <= 1'b0;
      sw2         <= 1'b0;
      sw3         <= 1'b0;
      sw4         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qcw_oscillator.sv
// Self-checking bench for qcw_oscillator: directed scenarios plus randomized reload/enable
// stress, checked against a period-position reference model.
module tb_qcw_oscillator;
  import qcw_pkg::*;

  localparam int DT   = 12;
  localparam int MINP = 2 * DT + 4;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] period_value;
  logic [7:0]  phase_shift;
  logic        period_done, signal_ref, sw1, sw2, sw3, sw4;
  logic [5:0]  obs;
  logic [5:0]  exp_out;

  int n_compared = 0;
  int n_failed   = 0;

  // reference model state: position in period, active P/H/D, first-period flag, shadows
  int m_run, m_k, m_p, m_h, m_d, m_first, m_sh_p, m_sh_ph;

  qcw_oscillator #(.DEADTIME(DT)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .load         (load),
    .period_value (period_value),
    .phase_shift  (phase_shift),
    .period_done  (period_done),
    .signal_ref   (signal_ref),
    .sw1          (sw1),
    .sw2          (sw2),
    .sw3          (sw3),
    .sw4          (sw4)
  );

  always #5 clk = ~clk;

  assign obs = {period_done, signal_ref, sw1, sw2, sw3, sw4};

  task automatic model_reset();
    m_run = 0; m_k = 0; m_p = 0; m_h = 0; m_d = 0; m_first = 1; m_sh_p = 0; m_sh_ph = 0;
  endtask

  task automatic model_cfg(input int pv, input int ph);
    int p;
    p = pv - (pv % 2);
    if (p < MINP) p = MINP;
    m_p = p;
    m_h = p / 2;
    m_d = (m_h * ph) / 256;
  endtask

  // Predicts the outputs registered at the coming edge and advances the model one clock.
  task automatic model_step();
    int b;
    bit s3, s4;
    if (!enable) begin
      exp_out = '0; m_run = 0; m_k = 0;
    end else if (!m_run) begin
      exp_out = '0; m_run = 1; m_k = 0; m_first = 1;
      if (load) model_cfg(int'(period_value), int'(phase_shift));
      else      model_cfg(m_sh_p, m_sh_ph);
    end else begin
      b  = (m_k - m_d + m_p) % m_p;
      s3 = (b >= DT) && (b < m_h) && !(m_first && m_k < m_d);
      s4 = (b >= m_h + DT) && !(m_first && m_k < m_d);
      exp_out = {m_k == m_p - 1, m_k < m_h, (m_k >= DT) && (m_k < m_h), m_k >= m_h + DT, s3, s4};
      if (m_k == m_p - 1) begin
        m_k = 0; m_first = 0;
        if (load) model_cfg(int'(period_value), int'(phase_shift));
        else      model_cfg(m_sh_p, m_sh_ph);
      end else begin
        m_k++;
      end
    end
    if (load) begin
      m_sh_p  = int'(period_value) & ~1;
      m_sh_ph = int'(phase_shift);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; period_value = '0; phase_shift = '0;
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (obs !== 6'b0) begin
      n_failed++;
      $display("[TB] FAIL reset_outputs: got %b want %b", obs, 6'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_nominal();
    int first_sw1 = -1, first_sw3 = -1, first_sw4 = -1, pulses = 0;
    load = 1'b1; period_value = 16'd600; phase_shift = 8'd128;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    for (int j = 1; j <= 1300; j++) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL nominal cyc %0d: got %b want %b", j, obs, exp_out);
      end
      if (sw1 && first_sw1 < 0) first_sw1 = j;
      if (sw3 && first_sw3 < 0) first_sw3 = j;
      if (sw4 && first_sw4 < 0) first_sw4 = j;
      if (period_done) pulses++;
    end
    n_compared++;
    if (first_sw1 != 13) begin n_failed++; $display("[TB] FAIL nominal_sw1_rise: got %0d want 13", first_sw1); end
    n_compared++;
    if (first_sw3 != 163) begin n_failed++; $display("[TB] FAIL nominal_sw3_rise: got %0d want 163", first_sw3); end
    n_compared++;
    if (first_sw4 != 463) begin n_failed++; $display("[TB] FAIL nominal_sw4_rise: got %0d want 463", first_sw4); end
    n_compared++;
    if (pulses != 2) begin n_failed++; $display("[TB] FAIL nominal_done_count: got %0d want 2", pulses); end
  endtask

  task automatic test_reload();
    int q[$];
    int t0, gap;
    for (int t = 0; t < 1100; t++) begin
      load = (t == 0);
      if (t == 0) begin period_value = 16'd480; phase_shift = 8'd200; end
      tick();
      load = 1'b0;
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL reload cyc %0d: got %b want %b", t, obs, exp_out);
      end
      if (period_done) q.push_back(t);
    end
    t0  = (q.size() > 0) ? q[0] : -1;
    gap = (q.size() > 1) ? q[1] - q[0] : -1;
    n_compared++;
    if (t0 != 499) begin n_failed++; $display("[TB] FAIL reload_old_period_end: got %0d want 499", t0); end
    n_compared++;
    if (gap != 480) begin n_failed++; $display("[TB] FAIL reload_new_period: got %0d want 480", gap); end
  endtask

  task automatic test_clamp();
    int q[$];
    int gap;
    for (int pass = 0; pass < 2; pass++) begin
      q.delete();
      for (int t = 0; t < (pass == 0 ? 700 : 1400); t++) begin
        load = (t == 0);
        if (t == 0) period_value = (pass == 0) ? 16'd10 : 16'd601;
        tick();
        load = 1'b0;
        n_compared++;
        if (obs !== exp_out) begin
          n_failed++;
          $display("[TB] FAIL clamp pass %0d cyc %0d: got %b want %b", pass, t, obs, exp_out);
        end
        if (period_done) q.push_back(t);
      end
      gap = (q.size() > 2) ? q[q.size()-1] - q[q.size()-2] : -1;
      n_compared++;
      if (gap != (pass == 0 ? 28 : 600)) begin
        n_failed++;
        $display("[TB] FAIL clamp_period pass %0d: got %0d want %0d", pass, gap, (pass == 0 ? 28 : 600));
      end
    end
  endtask

  task automatic test_phase_zero();
    enable = 1'b0;
    tick();
    n_compared++;
    if (obs !== 6'b0) begin n_failed++; $display("[TB] FAIL phase0_idle: got %b want %b", obs, 6'b0); end
    enable = 1'b1; load = 1'b1; period_value = 16'd200; phase_shift = 8'd0;
    tick();
    load = 1'b0;
    for (int j = 1; j <= 500; j++) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL phase0 cyc %0d: got %b want %b", j, obs, exp_out);
      end
      n_compared++;
      if ({sw3, sw4} !== {sw1, sw2}) begin
        n_failed++;
        $display("[TB] FAIL phase0_track cyc %0d: got %b want %b", j, {sw3, sw4}, {sw1, sw2});
      end
    end
  endtask

  task automatic test_enable_drop();
    int first_sw3 = -1;
    enable = 1'b0;
    tick();
    load = 1'b1; period_value = 16'd600; phase_shift = 8'd128;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    repeat (200) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin n_failed++; $display("[TB] FAIL drop_run: got %b want %b", obs, exp_out); end
    end
    enable = 1'b0;
    tick();
    n_compared++;
    if (obs !== 6'b0) begin n_failed++; $display("[TB] FAIL drop_outputs: got %b want %b", obs, 6'b0); end
    repeat (3) tick();
    enable = 1'b1;
    tick();
    for (int j = 1; j <= 460; j++) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL reenable cyc %0d: got %b want %b", j, obs, exp_out);
      end
      if (sw3 && first_sw3 < 0) first_sw3 = j;
    end
    n_compared++;
    if (first_sw3 != 163) begin n_failed++; $display("[TB] FAIL reenable_sw3_rise: got %0d want 163", first_sw3); end
  endtask

  task automatic test_random_stress();
    for (int t = 0; t < 3000; t++) begin
      enable = ($urandom_range(0, 99) != 0);
      load   = ($urandom_range(0, 19) == 0);
      period_value = 16'($urandom_range(0, 400));
      phase_shift  = 8'($urandom_range(0, 255));
      tick();
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL stress cyc %0d: got %b want %b", t, obs, exp_out);
      end
      n_compared++;
      if ((sw1 && sw2) || (sw3 && sw4)) begin
        n_failed++;
        $display("[TB] FAIL shoot_through cyc %0d: got %b want no overlap", t, obs);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; load = 1'b1; period_value = 16'd120; phase_shift = 8'd64;
    tick();
    load = 1'b0;
    repeat (70) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin n_failed++; $display("[TB] FAIL prereset_run: got %b want %b", obs, exp_out); end
    end
    #3 rst = 1'b1;
    #1;
    n_compared++;
    if (obs !== 6'b0) begin n_failed++; $display("[TB] FAIL async_reset: got %b want %b", obs, 6'b0); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 60; j++) begin
      tick();
      n_compared++;
      if (obs !== exp_out) begin
        n_failed++;
        $display("[TB] FAIL postreset cyc %0d: got %b want %b", j, obs, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reload();
    test_clamp();
    test_phase_zero();
    test_enable_drop();
    test_random_stress();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
